// File: rtl/mem_responder.sv
// Word-access memory responder for the multicycle MIPS core: unified RAM with
// configurable wait states, plus an MMIO page (LED, switches, cycle counter).
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  // Handshake: req/we/adr/wd are sampled only on a clock edge where the FSM is
  // IDLE; ready is high for exactly the single RESP cycle, and rd is valid then.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  wcnt;
  logic        lat_we;
  logic [31:2] lat_adr;
  logic [31:0] lat_wd;
  logic [31:0] cyc;
  logic [31:0] mem [0:(2**ADDR_BITS)-1];

  logic [31:2]          acc_adr;
  logic                 acc_we;
  logic                 acc_mmio;
  logic [ADDR_BITS-1:0] acc_idx;
  logic                 lat_mmio;
  logic [ADDR_BITS-1:0] lat_idx;
  logic                 to_resp;
  logic [31:0]          read_val;
  logic                 unused_bits;

  assign unused_bits = ^adr[1:0];

  // With zero wait states the access is decoded straight from the bus inputs,
  // since the latches only update on the same edge that enters RESP.
  assign acc_adr  = (state == S_IDLE) ? adr[31:2] : lat_adr;
  assign acc_we   = (state == S_IDLE) ? we : lat_we;
  assign acc_mmio = (acc_adr[31:16] == 16'hFFFF);
  assign acc_idx  = acc_adr[ADDR_BITS+1:2];
  assign lat_mmio = (lat_adr[31:16] == 16'hFFFF);
  assign lat_idx  = lat_adr[ADDR_BITS+1:2];

  assign to_resp = ((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                   ((state == S_WAIT) && (wcnt == 4'd0));

  assign ready = (state == S_RESP);

  always_comb begin
    read_val = 32'h0;
    if (acc_mmio) begin
      case (acc_adr[15:2])
        14'd0:   read_val = {16'h0, led};
        14'd1:   read_val = {16'h0, sw};
        14'd2:   read_val = cyc;
        default: read_val = 32'h0;
      endcase
    end else begin
      read_val = mem[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      wcnt    <= 4'd0;
      lat_we  <= 1'b0;
      lat_adr <= '0;
      lat_wd  <= 32'h0;
      rd      <= 32'h0;
      led     <= 16'h0;
      cyc     <= 32'h0;
    end else begin
      cyc <= cyc + 32'd1;
      if (to_resp && !acc_we) rd <= read_val;
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_we  <= we;
            lat_adr <= adr[31:2];
            lat_wd  <= wd;
            wcnt    <= WAIT_LOAD;
            state   <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0) state <= S_RESP;
          else              wcnt  <= wcnt - 4'd1;
        end
        S_RESP: begin
          state <= S_IDLE;
          if (lat_we && lat_mmio) begin
            if (lat_adr[15:2] == 14'd0) led <= lat_wd[15:0];
            // A counter clear lands on the same edge and beats the increment.
            if (lat_adr[15:2] == 14'd2) cyc <= 32'h0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; a reset in RESP suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && (state == S_RESP) && lat_we && !lat_mmio)
      mem[lat_idx] <= lat_wd;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a 2-wait-state instance (a) and a 0-wait-state
// instance (b), checked by per-instance response scoreboards.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_a, we_a, rdy_a, req_b, we_b, rdy_b;
  logic [31:0] adr_a, wd_a, rd_a, adr_b, wd_b, rd_b;
  logic [15:0] sw_a, led_a, sw_b, led_b;

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2), .INIT_FILE("")) u_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .adr(adr_a), .wd(wd_a),
    .rd(rd_a), .ready(rdy_a), .sw(sw_a), .led(led_a)
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0), .INIT_FILE("")) u_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .adr(adr_b), .wd(wd_b),
    .rd(rd_b), .ready(rdy_b), .sw(sw_b), .led(led_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected responses: rd range [lo, hi] and the time ready is sampled high.
  logic [31:0] exp_q_a[$], exp_hi_a[$], exp_q_b[$], exp_hi_b[$];
  longint      exp_t_a[$], exp_t_b[$];
  logic [31:0] last_rd [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_resp(input string name, input logic [31:0] act,
                            input logic [31:0] lo, input logic [31:0] hi, input longint t);
    n_cmp++;
    if (longint'($time) != t || act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: ready at %0t with rd %h, expected ready at %0d with rd in [%h,%h]",
               name, $time, act, t, lo, hi);
    end
  endtask

  // Monitors: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rdy_a === 1'b1) begin
      if (exp_t_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready_a: ready at %0t rd %h, expected no response", $time, rd_a);
      end else begin
        check_resp("resp_a", rd_a, exp_q_a.pop_front(), exp_hi_a.pop_front(), exp_t_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rdy_b === 1'b1) begin
      if (exp_t_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready_b: ready at %0t rd %h, expected no response", $time, rd_b);
      end else begin
        check_resp("resp_b", rd_b, exp_q_b.pop_front(), exp_hi_b.pop_front(), exp_t_b.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge where the next access may be offered.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                       input logic [31:0] lo, input logic [31:0] hi);
    int wc;
    wc = (d == 0) ? 2 : 0;
    if (d == 0) begin
      req_a = 1'b1; we_a = w; adr_a = a; wd_a = data;
      exp_q_a.push_back(lo); exp_hi_a.push_back(hi);
      exp_t_a.push_back(longint'($time) + 10 * (wc + 1));
    end else begin
      req_b = 1'b1; we_b = w; adr_b = a; wd_b = data;
      exp_q_b.push_back(lo); exp_hi_b.push_back(hi);
      exp_t_b.push_back(longint'($time) + 10 * (wc + 1));
    end
    @(negedge clk);
    if (d == 0) req_a = 1'b0;
    else        req_b = 1'b0;
    repeat (wc + 1) @(negedge clk);
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] data);
    issue(d, 1'b1, a, data, last_rd[d], last_rd[d]);
  endtask

  task automatic rdx(input int d, input logic [31:0] a, input logic [31:0] e);
    issue(d, 1'b0, a, 32'h0, e, e);
    last_rd[d] = e;
  endtask

  initial begin
    longint t0;
    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; adr_a = 32'h0; wd_a = 32'h0; sw_a = 16'h0;
    req_b = 1'b0; we_b = 1'b0; adr_b = 32'h0; wd_b = 32'h0; sw_b = 16'h0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_rd_a", rd_a, 32'h0);
    check("reset_ready_a", {31'h0, rdy_a}, 32'h0);
    check("reset_led_a", {16'h0, led_a}, 32'h0);
    check("reset_rd_b", rd_b, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // T1: basic write/read with 3-cycle latency
    wr(0, 32'h0000_0040, 32'h1234_5678);
    rdx(0, 32'h0000_0040, 32'h1234_5678);

    // T2: index wrap, ignored upper and byte-offset bits
    wr(0, 32'h0000_0000, 32'hAAAA_BBBB);
    rdx(0, 32'h0000_0400, 32'hAAAA_BBBB);
    rdx(0, 32'h0001_0040, 32'h1234_5678);
    rdx(0, 32'h0000_0043, 32'h1234_5678);

    // T3: MMIO page
    wr(0, 32'hFFFF_0000, 32'h0001_00FF);
    check("led_after_write", {16'h0, led_a}, 32'h0000_00FF);
    sw_a = 16'h5A5A;
    rdx(0, 32'hFFFF_0004, 32'h0000_5A5A);
    rdx(0, 32'hFFFF_0010, 32'h0000_0000);
    rdx(0, 32'hFFFF_0000, 32'h0000_00FF);
    wr(0, 32'hFFFF_0004, 32'hFFFF_FFFF);
    wr(0, 32'hFFFF_0010, 32'h0000_1111);
    check("led_unchanged", {16'h0, led_a}, 32'h0000_00FF);
    sw_a = 16'h1234;
    rdx(0, 32'hFFFF_0004, 32'h0000_1234);
    rdx(0, 32'h0000_0000, 32'hAAAA_BBBB);

    // T4: reset in WAIT aborts a write; reset beats a simultaneous req
    wr(0, 32'h0000_0080, 32'h0BAD_F00D);
    rdx(0, 32'h0000_0080, 32'h0BAD_F00D);
    req_a = 1'b1; we_a = 1'b1; adr_a = 32'h0000_0080; wd_a = 32'hDEAD_BEEF;
    @(negedge clk);
    req_a = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    check("rd_after_abort", rd_a, 32'h0);
    check("led_after_abort", {16'h0, led_a}, 32'h0);
    reset = 1'b1; req_a = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_a = 1'b0;
    repeat (4) @(negedge clk);
    rdx(0, 32'h0000_0080, 32'h0BAD_F00D);

    // T5: req held high -> one access every WAIT_CYCLES+2 cycles
    t0 = longint'($time);
    req_a = 1'b1; we_a = 1'b0; adr_a = 32'h0000_0040;
    for (int k = 0; k < 4; k++) begin
      exp_q_a.push_back(32'h1234_5678);
      exp_hi_a.push_back(32'h1234_5678);
      exp_t_a.push_back(t0 + 30 + 40 * k);
    end
    repeat (16) @(negedge clk);
    req_a = 1'b0;
    last_rd[0] = 32'h1234_5678;
    repeat (4) @(negedge clk);

    // T6: zero wait states on instance b
    wr(1, 32'h0000_0040, 32'hCAFE_F00D);
    rdx(1, 32'h0000_0040, 32'hCAFE_F00D);
    wr(1, 32'hFFFF_0000, 32'h0000_A5C3);
    check("led_b", {16'h0, led_b}, 32'h0000_A5C3);
    wr(1, 32'hFFFF_0008, 32'h0);
    issue(1, 1'b0, 32'hFFFF_0008, 32'h0, 32'h0, 32'h3);

    repeat (6) @(negedge clk);
    check("pending_a", exp_t_a.size(), 32'h0);
    check("pending_b", exp_t_b.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
